// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_ctrl_pkg;

    localparam int unsigned RA_W_DEF     = 5;
    localparam int unsigned FSEL_REGFILE = 0;

    // One post-decode stage as seen by the hazard logic
    typedef struct packed {
        logic                valid;
        logic [RA_W_DEF-1:0] rd;
        logic                reg_write;
        logic                is_load;
    } stage_rec_t;

    localparam stage_rec_t NOP_REC = '{valid: 1'b0, rd: '0, reg_write: 1'b0, is_load: 1'b0};

endpackage

// File: rtl/mc_countdown.sv
// Multicycle-EX occupancy counter: loads MC_LAT-1 on entry, counts down, flags busy.
module mc_countdown #(
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    output logic busy_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(MC_LAT - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // busy is kept as its own flop so the hold decision needs no compare on cnt_q
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != '0);
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller: load-use stall, branch flush, multicycle hold, EX operand selects.
// Optional saturating perf counters under HAZARD_PERF_EN; reset_i is active-low.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned PIPE_DEPTH = 3,
    parameter int unsigned RA_W       = RA_W_DEF,
    parameter int unsigned MC_LAT     = 4,
    parameter int unsigned FSEL_W     = $clog2(PIPE_DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              id_valid_i,
    input  logic [RA_W-1:0]   id_rs1_i,
    input  logic [RA_W-1:0]   id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [RA_W-1:0]   id_rd_i,
    input  logic              id_reg_write_i,
    input  logic              id_is_load_i,
    input  logic              id_is_mc_i,
    input  logic              ex_branch_taken_i,
    output logic              stall_if_o,
    output logic              stall_id_o,
    output logic              flush_id_o,
    output logic              bubble_ex_o,
    output logic              ex_hold_o,
    output logic [FSEL_W-1:0] fwd_a_sel_o,
    output logic [FSEL_W-1:0] fwd_b_sel_o,
    output logic [31:0]       perf_stall_cnt_o,
    output logic [31:0]       perf_flush_cnt_o
);

    localparam int unsigned MC_CNT_W = 4;

    stage_rec_t        rec_q [PIPE_DEPTH];
    stage_rec_t        rec_d [PIPE_DEPTH];
    logic [RA_W-1:0]   ex_rs1_q, ex_rs1_d;
    logic [RA_W-1:0]   ex_rs2_q, ex_rs2_d;
    logic              busy;
    logic              mc_load;
    logic              load_use;

    mc_countdown #(
        .MC_LAT (MC_LAT),
        .CNT_W  (MC_CNT_W)
    ) u_mc (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (mc_load),
        .busy_o  (busy)
    );

    function automatic logic fwd_hit(input stage_rec_t r, input int k, input logic [RA_W-1:0] tag);
        // A load's data only exists from WB onward, so it cannot forward from MEM
        return r.valid && r.reg_write && (r.rd != '0) && (RA_W'(r.rd) == tag)
               && (!r.is_load || k >= 2);
    endfunction

    always_comb begin
        load_use = 1'b0;
        if (rec_q[0].valid && rec_q[0].is_load && (rec_q[0].rd != '0)) begin
            load_use = (id_rs1_used_i && (id_rs1_i == RA_W'(rec_q[0].rd)))
                    || (id_rs2_used_i && (id_rs2_i == RA_W'(rec_q[0].rd)));
        end
    end

    // Priority: multicycle hold > taken branch > load-use; all forced low while in reset
    always_comb begin
        stall_if_o  = 1'b0;
        stall_id_o  = 1'b0;
        flush_id_o  = 1'b0;
        bubble_ex_o = 1'b0;
        ex_hold_o   = 1'b0;
        if (reset_i) begin
            if (busy) begin
                stall_if_o = 1'b1;
                stall_id_o = 1'b1;
                ex_hold_o  = 1'b1;
            end else if (ex_branch_taken_i) begin
                flush_id_o  = 1'b1;
                bubble_ex_o = 1'b1;
            end else if (load_use) begin
                stall_if_o  = 1'b1;
                stall_id_o  = 1'b1;
                bubble_ex_o = 1'b1;
            end
        end
    end

    always_comb begin
        rec_d    = rec_q;
        ex_rs1_d = ex_rs1_q;
        ex_rs2_d = ex_rs2_q;
        mc_load  = 1'b0;
        for (int k = 2; k < int'(PIPE_DEPTH); k++) begin
            rec_d[k] = rec_q[k-1];
        end
        if (busy) begin
            rec_d[1] = NOP_REC;
        end else begin
            rec_d[1]           = rec_q[0];
            rec_d[0].valid     = id_valid_i && !bubble_ex_o;
            rec_d[0].rd        = RA_W_DEF'(id_rd_i);
            rec_d[0].reg_write = id_reg_write_i;
            rec_d[0].is_load   = id_is_load_i;
            ex_rs1_d           = id_rs1_used_i ? id_rs1_i : '0;
            ex_rs2_d           = id_rs2_used_i ? id_rs2_i : '0;
            mc_load            = id_valid_i && id_is_mc_i && !bubble_ex_o;
        end
    end

    // Walk oldest to youngest so the youngest matching stage wins
    always_comb begin
        fwd_a_sel_o = FSEL_W'(FSEL_REGFILE);
        fwd_b_sel_o = FSEL_W'(FSEL_REGFILE);
        for (int k = int'(PIPE_DEPTH) - 1; k >= 1; k--) begin
            if (fwd_hit(rec_q[k], k, ex_rs1_q)) fwd_a_sel_o = FSEL_W'(k);
            if (fwd_hit(rec_q[k], k, ex_rs2_q)) fwd_b_sel_o = FSEL_W'(k);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
                rec_q[k] <= NOP_REC;
            end
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
        end else begin
            rec_q    <= rec_d;
            ex_rs1_q <= ex_rs1_d;
            ex_rs2_q <= ex_rs2_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_id_o && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_id_o && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_flush_cnt_o = flush_cnt_q;
`else
    assign perf_stall_cnt_o = '0;
    assign perf_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed vector bench for pipeline_hazard_ctrl (PIPE_DEPTH=3, MC_LAT=4).
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       mc;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
    } id_t;

    // flags = {stall_if, stall_id, flush_id, bubble_ex, ex_hold}
    typedef struct packed {
        id_t        id;
        logic       br;
        logic [4:0] flags;
        logic [1:0] a;
        logic [1:0] b;
    } vec_t;

    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_LU   = 5'b11010;
    localparam logic [4:0] F_BR   = 5'b00110;
    localparam logic [4:0] F_MC   = 5'b11001;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_is_load, id_is_mc, br;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       stall_if, stall_id, flush_id, bubble_ex, ex_hold;
    logic [1:0] fwd_a, fwd_b;
    logic [31:0] perf_stall, perf_flush;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk_i             (clk),
        .reset_i           (reset_n),
        .id_valid_i        (id_valid),
        .id_rs1_i          (id_rs1),
        .id_rs2_i          (id_rs2),
        .id_rs1_used_i     (id_rs1_used),
        .id_rs2_used_i     (id_rs2_used),
        .id_rd_i           (id_rd),
        .id_reg_write_i    (id_reg_write),
        .id_is_load_i      (id_is_load),
        .id_is_mc_i        (id_is_mc),
        .ex_branch_taken_i (br),
        .stall_if_o        (stall_if),
        .stall_id_o        (stall_id),
        .flush_id_o        (flush_id),
        .bubble_ex_o       (bubble_ex),
        .ex_hold_o         (ex_hold),
        .fwd_a_sel_o       (fwd_a),
        .fwd_b_sel_o       (fwd_b),
        .perf_stall_cnt_o  (perf_stall),
        .perf_flush_cnt_o  (perf_flush)
    );

    function automatic id_t op(input logic [4:0] rd, input logic rw, input logic ld, input logic mc,
                               input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2);
        id_t r;
        r.vld = 1'b1; r.rd = rd; r.rw = rw; r.ld = ld; r.mc = mc;
        r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
        return r;
    endfunction

    task automatic row(input id_t i, input logic b, input logic [4:0] f, input logic [1:0] ea, input logic [1:0] eb);
        vec_t v;
        v.id = i; v.br = b; v.flags = f; v.a = ea; v.b = eb;
        vecs.push_back(v);
    endtask

    task automatic apply(input id_t i, input logic b);
        id_valid = i.vld; id_rd = i.rd; id_reg_write = i.rw; id_is_load = i.ld; id_is_mc = i.mc;
        id_rs1 = i.rs1; id_rs1_used = i.u1; id_rs2 = i.rs2; id_rs2_used = i.u2;
        br = b;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic chk_outs(input string nm, input logic [4:0] f, input logic [1:0] ea, input logic [1:0] eb);
        chk({nm, " flags"}, 32'({stall_if, stall_id, flush_id, bubble_ex, ex_hold}), 32'(f));
        chk({nm, " fwd_a"}, 32'(fwd_a), 32'(ea));
        chk({nm, " fwd_b"}, 32'(fwd_b), 32'(eb));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        id_t nop, add5, add6_51, add7, lw5_1, add6_50, lw5_2, add8, add9, add0, lw0, add6_00;
        id_t mul10, add11, lw12, mul13;
        nop     = '0;
        add5    = op(5'd5,  1, 0, 0, 5'd1,  1, 5'd2, 1);
        add6_51 = op(5'd6,  1, 0, 0, 5'd5,  1, 5'd1, 1);
        add7    = op(5'd7,  1, 0, 0, 5'd5,  1, 5'd5, 1);
        lw5_1   = op(5'd5,  1, 1, 0, 5'd1,  1, 5'd0, 0);
        add6_50 = op(5'd6,  1, 0, 0, 5'd5,  1, 5'd0, 1);
        lw5_2   = op(5'd5,  1, 1, 0, 5'd2,  1, 5'd0, 0);
        add8    = op(5'd8,  1, 0, 0, 5'd5,  1, 5'd5, 1);
        add9    = op(5'd9,  1, 0, 0, 5'd5,  1, 5'd0, 1);
        add0    = op(5'd0,  1, 0, 0, 5'd1,  1, 5'd2, 1);
        lw0     = op(5'd0,  1, 1, 0, 5'd3,  1, 5'd0, 0);
        add6_00 = op(5'd6,  1, 0, 0, 5'd0,  1, 5'd0, 1);
        mul10   = op(5'd10, 1, 0, 1, 5'd1,  1, 5'd2, 1);
        add11   = op(5'd11, 1, 0, 0, 5'd10, 1, 5'd0, 1);
        lw12    = op(5'd12, 1, 1, 0, 5'd1,  1, 5'd0, 0);
        mul13   = op(5'd13, 1, 0, 1, 5'd12, 1, 5'd0, 1);

        row(nop,     0, F_NONE, 2'd0, 2'd0);  // 0  idle after reset
        row(add5,    0, F_NONE, 2'd0, 2'd0);  // 1  back-to-back ALU forwarding
        row(add6_51, 0, F_NONE, 2'd0, 2'd0);
        row(add7,    0, F_NONE, 2'd1, 2'd0);
        row(nop,     0, F_NONE, 2'd2, 2'd2);
        row(lw5_1,   0, F_NONE, 2'd0, 2'd0);  // 5  load-use
        row(add6_50, 0, F_LU,   2'd0, 2'd0);
        row(add6_50, 0, F_NONE, 2'd0, 2'd0);
        row(nop,     0, F_NONE, 2'd2, 2'd0);
        row(lw5_2,   0, F_NONE, 2'd0, 2'd0);  // 9  branch beats load-use
        row(add8,    1, F_BR,   2'd0, 2'd0);
        row(add9,    0, F_NONE, 2'd0, 2'd0);
        row(nop,     0, F_NONE, 2'd2, 2'd0);
        row(add0,    0, F_NONE, 2'd0, 2'd0);  // 13 x0 never forwards or stalls
        row(lw0,     0, F_NONE, 2'd0, 2'd0);
        row(add6_00, 0, F_NONE, 2'd0, 2'd0);
        row(nop,     0, F_NONE, 2'd0, 2'd0);
        row(mul10,   0, F_NONE, 2'd0, 2'd0);  // 17 multicycle, branch ignored while busy
        row(add11,   0, F_MC,   2'd0, 2'd0);
        row(add11,   0, F_MC,   2'd0, 2'd0);
        row(add11,   1, F_MC,   2'd0, 2'd0);
        row(add11,   0, F_NONE, 2'd0, 2'd0);
        row(nop,     0, F_NONE, 2'd1, 2'd0);
        row(lw12,    0, F_NONE, 2'd0, 2'd0);  // 23 load-use stall delays mc entry
        row(mul13,   0, F_LU,   2'd0, 2'd0);
        row(mul13,   0, F_NONE, 2'd0, 2'd0);
        row(nop,     0, F_MC,   2'd2, 2'd0);

        // Outputs held at zero during reset even with a branch and a load-use pattern driven
        reset_n = 1'b0;
        apply(add6_51, 1'b1);
        #3;
        chk_outs("reset", F_NONE, 2'd0, 2'd0);
        chk("reset perf_stall", perf_stall, 32'd0);
        chk("reset perf_flush", perf_flush, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        apply(nop, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            apply(vecs[i].id, vecs[i].br);
            #1;
            chk_outs($sformatf("row%0d", i), vecs[i].flags, vecs[i].a, vecs[i].b);
            exp_stall += int'(vecs[i].flags[3]);
            exp_flush += int'(vecs[i].flags[2]);
        end

        @(negedge clk);
`ifdef HAZARD_PERF_EN
        chk("perf_stall count", perf_stall, 32'(exp_stall));
        chk("perf_flush count", perf_flush, 32'(exp_flush));
`else
        chk("perf_stall tied", perf_stall, 32'd0);
        chk("perf_flush tied", perf_flush, 32'd0);
`endif
        // Still mid-multicycle (two hold cycles left), then reset asynchronously
        apply(nop, 1'b0);
        #1;
        chk_outs("pre-reset busy", F_MC, 2'd0, 2'd0);
        #1;
        reset_n = 1'b0;
        apply(add6_50, 1'b1);
        #1;
        chk_outs("async reset", F_NONE, 2'd0, 2'd0);
        chk("async reset perf_stall", perf_stall, 32'd0);
        chk("async reset perf_flush", perf_flush, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        apply(nop, 1'b0);
        #1;
        chk_outs("post-reset 0", F_NONE, 2'd0, 2'd0);
        @(negedge clk);
        apply(add5, 1'b0);
        #1;
        chk_outs("post-reset 1", F_NONE, 2'd0, 2'd0);
        @(negedge clk);
        apply(nop, 1'b0);
        #1;
        chk_outs("post-reset 2", F_NONE, 2'd0, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
